// File: rtl/arbiter_rr_packet.sv
// Packet-level round-robin arbiter: N requesters share one output stream and the
// granted requester keeps the output until its last beat has been accepted.
module arbiter_rr_packet #(
    parameter int N                = 8,
    parameter int DW               = 32,
    parameter int INIT_LOWEST_PRIO = N - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_id,
    output logic                 busy
);
    // state     | meaning
    // ST_IDLE   | no owner; a winner is picked from in_valid
    // ST_LOCKED | owner_q is connected to the output until its last beat is accepted

    localparam int IW = $clog2(N);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] low_prio_q, low_prio_d;
    logic [IW-1:0] winner;
    logic [IW-1:0] scan_idx;
    logic          win_found;
    logic          owner_done;
    logic [DW-1:0] data_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_split
        assign data_arr[g] = in_data[g*DW +: DW];
    end

    // Scan starts just after the lowest-priority index and wraps around to it.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = IW'((int'(low_prio_q) + k) % N);
            if (!win_found && in_valid[scan_idx]) begin
                winner    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    assign owner_done = in_valid[owner_q] & out_ready & in_last[owner_q];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        low_prio_d = low_prio_q;
        in_ready   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        out_id     = '0;
        busy       = 1'b0;

        // Outputs are forced idle while rst is high so an aborted packet leaks no beat.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        state_d = ST_LOCKED;
                        owner_d = winner;
                    end
                end
                ST_LOCKED: begin
                    busy              = 1'b1;
                    out_id            = owner_q;
                    out_valid         = in_valid[owner_q];
                    out_last          = in_last[owner_q];
                    out_data          = data_arr[owner_q];
                    in_ready[owner_q] = out_ready;
                    if (owner_done) begin
                        state_d    = ST_IDLE;
                        low_prio_d = owner_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            low_prio_q <= IW'(INIT_LOWEST_PRIO);
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            low_prio_q <= low_prio_d;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_packet.sv
// Bench for arbiter_rr_packet: per-requester packet queues feed the DUT, a packet-level
// round-robin model predicts beats into a scoreboard that a negedge monitor drains.
module tb_arbiter_rr_packet;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_last;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic              out_last;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic [IW-1:0]     out_id;
    logic              busy;

    always #5 clk = ~clk;

    arbiter_rr_packet #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_id    (out_id),
        .busy      (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    beat_t src_q [N][$];
    exp_t  exp_q [$];
    int    grant_log [$];
    int    grant_cyc [$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 0, locked_now = 0, m_busy = 0, gen_en = 0, bub_en = 0;
    int    m_owner = 0, m_lowp = N - 1, rdy_pct = 100, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add_packet(input int r, input int nb);
        for (int b = 0; b < nb; b++) begin
            beat_t bt;
            bt.data = DW'($urandom);
            bt.last = (b == nb - 1);
            src_q[r].push_back(bt);
        end
    endtask

    function automatic int rr_pick(input int lowp);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (lowp + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, let the model arbitrate, then account accepted beats.
    task automatic step();
        int w;
        @(posedge clk);
        #1;
        cyc++;
        locked_now = m_busy;
        if (gen_en && $urandom_range(0, 99) < 35) begin
            int r;
            r = $urandom_range(0, N - 1);
            if (src_q[r].size() < 12) add_packet(r, $urandom_range(1, 4));
        end
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                in_valid[i] = !(bub_en && locked_now && i == m_owner && $urandom_range(0, 3) == 0);
                in_last[i]  = src_q[i][0].last;
                in_data[i*DW +: DW] = src_q[i][0].data;
            end else begin
                in_valid[i] = 1'b0;
                in_last[i]  = 1'($urandom_range(0, 1));
                in_data[i*DW +: DW] = DW'($urandom);
            end
        end
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        if (!m_busy) begin
            w = rr_pick(m_lowp);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                grant_log.push_back(w);
                grant_cyc.push_back(cyc);
                for (int b = 0; b < src_q[w].size(); b++) begin
                    exp_t e;
                    e.id   = IW'(w);
                    e.data = src_q[w][b].data;
                    e.last = src_q[w][b].last;
                    exp_q.push_back(e);
                    if (e.last) break;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i] && src_q[i].size() > 0) begin
                beat_t bt;
                bt = src_q[i].pop_front();
                if (bt.last && i == m_owner) begin
                    m_busy = 1'b0;
                    m_lowp = i;
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((m_busy || any_pending()) && n < 1000) begin
            step();
            n++;
        end
        chk({name, "_drain_in_time"}, (n < 1000), 1'b1);
        chk({name, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        grant_log.delete();
        grant_cyc.delete();
        m_busy     = 0;
        locked_now = 0;
        m_owner    = 0;
        m_lowp     = N - 1;
        mon_en     = 1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                logic [N-1:0] rdy_exp;
                exp_t         e;
                rdy_exp = '0;
                if (locked_now) rdy_exp[m_owner] = out_ready;
                chk("busy", busy, locked_now);
                chk("in_ready", in_ready, rdy_exp);
                chk("out_valid", out_valid, locked_now ? in_valid[m_owner] : 1'b0);
                chk("out_id", out_id, locked_now ? m_owner : 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat: got unexpected beat from id %0d, want none", out_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_id", out_id, e.id);
                        chk("beat_data", out_data, e.data);
                        chk("beat_last", out_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        in_data   = {N{16'hA5C3}};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, '0);
        chk("rst_out_id", out_id, '0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = '0;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_out_id", out_id, '0);

        // Requesters 1 and 2 continuously pending: ownership alternates starting at 1.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            add_packet(1, 2);
            add_packet(2, 2);
        end
        drain("alt12");
        chk("alt12_count", grant_log.size(), 6);
        for (int k = 0; k < grant_log.size(); k++) chk("alt12_order", grant_log[k], (k % 2 == 0) ? 1 : 2);

        // All four with 3-beat packets: order 0,1,2,3,0 and a grant every 4 cycles.
        do_reset();
        for (int i = 0; i < N; i++) add_packet(i, 3);
        add_packet(0, 3);
        drain("all4");
        chk("all4_count", grant_log.size(), 5);
        for (int k = 0; k < grant_log.size(); k++) chk("all4_order", grant_log[k], k % N);
        for (int k = 1; k < grant_cyc.size(); k++) chk("all4_gap", grant_cyc[k] - grant_cyc[k-1], 4);

        // Single-beat packets from requester 1: one transfer every 2 cycles.
        do_reset();
        for (int p = 0; p < 4; p++) add_packet(1, 1);
        drain("single1");
        chk("single1_count", grant_log.size(), 4);
        for (int k = 1; k < grant_cyc.size(); k++) chk("single1_gap", grant_cyc[k] - grant_cyc[k-1], 2);

        // Random traffic with bubbles and out_ready stalls.
        do_reset();
        gen_en  = 1;
        bub_en  = 1;
        rdy_pct = 60;
        repeat (1500) step();
        gen_en = 0;
        drain("random");
        bub_en  = 0;
        rdy_pct = 100;

        // Reset during beat 2 of a requester-3 packet aborts it; index 0 wins afterwards.
        do_reset();
        mon_en = 0;
        @(posedge clk);
        #1;
        in_valid  = 4'b1000;
        in_last   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abort_idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_locked_busy", busy, 1'b1);
        chk("abort_locked_id", out_id, 2'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_during_rst_out_valid", out_valid, 1'b0);
        chk("abort_during_rst_in_ready", in_ready, '0);
        chk("abort_during_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 4'b1111;
        @(negedge clk);
        chk("abort_after_busy", busy, 1'b0);
        chk("abort_after_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_regrant_busy", busy, 1'b1);
        chk("abort_regrant_id", out_id, 2'd0);
        chk("abort_regrant_ready", in_ready, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_packet.md
ARBITER_RR_PACKET -- requirements
Module: arbiter_rr_packet

Interface
REQ-001 SHALL have parameter N, default 8: number of requesters, N >= 2.
REQ-002 SHALL have parameter DW, default 32: data width per requester.
REQ-003 SHALL have parameter INIT_LOWEST_PRIO, default N-1: requester index holding lowest priority after reset.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  N: per-requester beat valid.
REQ-007 SHALL have port in_last  input  N: per-requester last beat of packet.
REQ-008 SHALL have port in_data  input  N*DW: requester i data at bits [i*DW +: DW].
REQ-009 SHALL have port in_ready  output  N: per-requester beat accepted when in_valid[i]&in_ready[i].
REQ-010 SHALL have port out_valid  output  1: shared resource beat valid.
REQ-011 SHALL have port out_last  output  1: last beat of forwarded packet.
REQ-012 SHALL have port out_data  output  DW: forwarded data.
REQ-013 SHALL have port out_ready  input  1: shared resource accepts beat.
REQ-014 SHALL have port out_id  output  $clog2(N): index of current owner.
REQ-015 SHALL have port busy  output  1: high while in LOCKED state.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-017 In IDLE, SHALL drive out_valid=0, in_ready=0 and busy=0.
REQ-018 In IDLE with any in_valid high, SHALL pick a winner round-robin and enter LOCKED next cycle; owner register = winner.
REQ-019 Round-robin SHALL give highest priority to index (lowest_prio+1) mod N, descending cyclically to lowest_prio itself.
REQ-020 In IDLE with in_valid all zero, SHALL remain in IDLE; owner and lowest_prio unchanged.
REQ-021 In LOCKED, SHALL drive out_valid=in_valid[owner], out_last=in_last[owner], out_data=in_data[owner], in_ready[owner]=out_ready, all other in_ready=0.
REQ-022 out_id SHALL equal owner in LOCKED; 0 in IDLE.
REQ-023 In LOCKED, requests from non-owners SHALL be ignored; no preemption.
REQ-024 On out_valid&out_ready&out_last in LOCKED, SHALL return to IDLE and set lowest_prio=owner next cycle.
REQ-025 A beat with in_valid[owner]=0 in LOCKED (bubble) SHALL hold LOCKED, with no transfer.
REQ-026 Arbitration latency SHALL be exactly 1 cycle from IDLE request to out_valid; every packet is followed by one IDLE cycle.
REQ-027 Single-beat packets (in_last=1 on first beat) SHALL complete in one LOCKED cycle when out_ready=1.
REQ-028 in_ready SHALL never depend on in_valid of the same requester (no combinational valid->ready loop).
REQ-029 Indices SHALL wrap modulo N; lowest_prio=N-1 makes index 0 highest.

Reset
REQ-030 On rst, SHALL enter IDLE, set lowest_prio=INIT_LOWEST_PRIO, owner=0.
REQ-031 During and the cycle after rst, out_valid=0, in_ready=0, busy=0, out_id=0; out_data and out_last are don't-care while out_valid=0.
REQ-032 rst asserted mid-packet SHALL abort the packet immediately; no further beats forwarded, priority state reinitialised.

Verification
REQ-033 After reset, N=4, in_valid=4'b0110 constant -> owner 1 first, then 2, then 1, alternating; busy low one cycle between packets.
REQ-034 All four request, 3-beat packets, out_ready=1 -> grant order 0,1,2,3,0; each packet 3 LOCKED cycles + 1 IDLE cycle.
REQ-035 Owner 2 mid-packet, requester 0 raises in_valid -> in_ready[0]=0 until owner 2's last beat accepted; then 0 granted next arbitration.
REQ-036 out_ready toggling 1,0,1,0 during 4-beat packet -> exactly 4 beats transferred, data order preserved, out_last only on beat 4.
REQ-037 rst pulsed during beat 2 of requester 3 packet -> next cycle busy=0, out_valid=0; with all requesting, next owner is 0.
REQ-038 Single-beat packets from requester 1 only, out_ready=1 -> one transfer every 2 cycles, out_id=1, out_last=1 each beat.
